// File: rtl/dram_fifo_pkg.sv
// dram_fifo_pkg: shared constant helpers for the dram_fifo slice.
package dram_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/dram_fifo_dram.sv
// dram_fifo_dram: unreset storage array, one write port and two async read ports.
module dram_fifo_dram #(
    parameter int DW = 32,
    parameter int AW = 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr0_i,
    output logic [DW-1:0] rdata0_o,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata1_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/dram_fifo.sv
// dram_fifo: first-word fall-through FIFO over a distributed-RAM array.
// Define DRAM_FIFO_ERR_EN to add a sticky err_o flag for ignored push/pop requests.
module dram_fifo
    import dram_fifo_pkg::*;
#(
    parameter int SZ = 2,
    parameter int DW = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [DW-1:0]         data_i,
    output logic                  full_o,
    input  logic                  pop_i,
    output logic [DW-1:0]         data_o,
    output logic                  empty_o,
    output logic [clog2(SZ):0]    usage_o
`ifdef DRAM_FIFO_ERR_EN
    ,
    output logic                  err_o
`endif
);

    localparam int AW = clog2(SZ);
    localparam int PW = AW + 1;

    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic          push_ok, pop_ok, we;
    logic [DW-1:0] rd1_unused;

    always_comb begin
        empty_o = wp_q == rp_q;
        full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
        usage_o = wp_q - rp_q;
        pop_ok  = pop_i && !empty_o;
        push_ok = push_i && (!full_o || pop_ok);
        wp_d    = wp_q + PW'(push_ok);
        rp_d    = rp_q + PW'(pop_ok);
        // storage must not change while reset holds the pointers
        we      = push_ok && rst_n_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end

`ifdef DRAM_FIFO_ERR_EN
    logic err_q, err_d;

    always_comb err_d = err_q || (push_i && full_o && !pop_ok) || (pop_i && empty_o);

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) err_q <= 1'b0;
        else          err_q <= err_d;

    assign err_o = err_q;
`endif

    dram_fifo_dram #(.DW(DW), .AW(AW)) u_dram (
        .clk_i    (clk_i),
        .we_i     (we),
        .waddr_i  (wp_q[AW-1:0]),
        .wdata_i  (data_i),
        .raddr0_i (rp_q[AW-1:0]),
        .rdata0_o (data_o),
        .raddr1_i (rp_q[AW-1:0]),
        .rdata1_o (rd1_unused)
    );

endmodule

// File: tb/tb_dram_fifo.sv
// tb_dram_fifo: table-driven directed check of dram_fifo at SZ=4, DW=32.
module tb_dram_fifo;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        push_i = 1'b0;
    logic        pop_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        full_o, empty_o;
    logic [31:0] data_o;
    logic [2:0]  usage_o;
`ifdef DRAM_FIFO_ERR_EN
    logic        err_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    dram_fifo #(.SZ(4), .DW(32)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_i),
        .data_i  (data_i),
        .full_o  (full_o),
        .pop_i   (pop_i),
        .data_o  (data_o),
        .empty_o (empty_o),
        .usage_o (usage_o)
`ifdef DRAM_FIFO_ERR_EN
        ,
        .err_o   (err_o)
`endif
    );

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] din;
        logic        cpre;
        logic [31:0] pre;
        logic        emp;
        logic        ful;
        logic [2:0]  use_n;
        logic        cpost;
        logic [31:0] post;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic push, pop, input logic [31:0] din,
                               input logic cpre, input logic [31:0] pre,
                               input logic emp, ful, input logic [2:0] use_n,
                               input logic cpost, input logic [31:0] post, input logic err);
        vec_t r;
        r = '{push, pop, din, cpre, pre, emp, ful, use_n, cpost, post, err};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        //              push pop din        cpre pre        emp ful use cpost post       err
        tbl.push_back(v(1, 0, 32'hA5A5A5A5, 0, 0,           0, 0, 1, 1, 32'hA5A5A5A5, 0));
        tbl.push_back(v(0, 1, 0,            1, 32'hA5A5A5A5, 1, 0, 0, 0, 0,           0));
        tbl.push_back(v(1, 0, 1,            0, 0,           0, 0, 1, 1, 1,            0));
        tbl.push_back(v(1, 0, 2,            0, 0,           0, 0, 2, 1, 1,            0));
        tbl.push_back(v(1, 0, 3,            0, 0,           0, 0, 3, 1, 1,            0));
        tbl.push_back(v(1, 0, 4,            0, 0,           0, 1, 4, 1, 1,            0));
        tbl.push_back(v(1, 0, 5,            0, 0,           0, 1, 4, 1, 1,            1));
        tbl.push_back(v(1, 1, 9,            1, 1,           0, 1, 4, 1, 2,            1));
        tbl.push_back(v(0, 1, 0,            1, 2,           0, 0, 3, 1, 3,            1));
        tbl.push_back(v(0, 1, 0,            1, 3,           0, 0, 2, 1, 4,            1));
        tbl.push_back(v(0, 1, 0,            1, 4,           0, 0, 1, 1, 9,            1));
        tbl.push_back(v(0, 1, 0,            1, 9,           1, 0, 0, 0, 0,            1));
        tbl.push_back(v(0, 1, 0,            0, 0,           1, 0, 0, 0, 0,            1));
        tbl.push_back(v(1, 1, 7,            0, 0,           0, 0, 1, 1, 7,            1));
        tbl.push_back(v(1, 0, 8,            0, 0,           0, 0, 2, 1, 7,            1));
        tbl.push_back(v(1, 0, 6,            0, 0,           0, 0, 3, 1, 7,            1));
        tbl.push_back(v(0, 1, 0,            1, 7,           0, 0, 2, 1, 8,            1));
        tbl.push_back(v(0, 1, 0,            1, 8,           0, 0, 1, 1, 6,            1));
        tbl.push_back(v(0, 1, 0,            1, 6,           1, 0, 0, 0, 0,            1));
        tbl.push_back(v(1, 0, 1,            0, 0,           0, 0, 1, 1, 1,            1));
        tbl.push_back(v(1, 0, 2,            0, 0,           0, 0, 2, 1, 1,            1));
        tbl.push_back(v(1, 0, 3,            0, 0,           0, 0, 3, 1, 1,            1));
        tbl.push_back(v(1, 0, 4,            0, 0,           0, 1, 4, 1, 1,            1));
        tbl.push_back(v(1, 0, 5,            0, 0,           0, 1, 4, 1, 1,            1));
        tbl.push_back(v(0, 1, 0,            1, 1,           0, 0, 3, 1, 2,            1));
        tbl.push_back(v(0, 1, 0,            1, 2,           0, 0, 2, 1, 3,            1));
        tbl.push_back(v(0, 1, 0,            1, 3,           0, 0, 1, 1, 4,            1));
        tbl.push_back(v(0, 1, 0,            1, 4,           1, 0, 0, 0, 0,            1));
        tbl.push_back(v(1, 0, 10,           0, 0,           0, 0, 1, 1, 10,           1));
        tbl.push_back(v(1, 0, 20,           0, 0,           0, 0, 2, 1, 10,           1));
        tbl.push_back(v(1, 0, 30,           0, 0,           0, 0, 3, 1, 10,           1));

        #12;
        chk("reset_empty", 32'(empty_o), 1);
        chk("reset_full", 32'(full_o), 0);
        chk("reset_usage", 32'(usage_o), 0);
`ifdef DRAM_FIFO_ERR_EN
        chk("reset_err", 32'(err_o), 0);
`endif
        @(negedge clk_i);
        rst_n_i = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk_i);
            push_i = tbl[i].push;
            pop_i  = tbl[i].pop;
            data_i = tbl[i].din;
            #1;
            if (tbl[i].cpre) chk($sformatf("v%0d_pop_data", i), data_o, tbl[i].pre);
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_empty", i), 32'(empty_o), 32'(tbl[i].emp));
            chk($sformatf("v%0d_full", i), 32'(full_o), 32'(tbl[i].ful));
            chk($sformatf("v%0d_usage", i), 32'(usage_o), 32'(tbl[i].use_n));
            if (tbl[i].cpost) chk($sformatf("v%0d_head", i), data_o, tbl[i].post);
`ifdef DRAM_FIFO_ERR_EN
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].err));
`endif
        end

        // mid-cycle reset with three entries queued, push held during reset
        @(negedge clk_i);
        push_i = 1'b0;
        pop_i  = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty_o), 1);
        chk("mid_rst_usage", 32'(usage_o), 0);
        chk("mid_rst_full", 32'(full_o), 0);
`ifdef DRAM_FIFO_ERR_EN
        chk("mid_rst_err", 32'(err_o), 0);
`endif
        push_i = 1'b1;
        pop_i  = 1'b1;
        data_i = 32'hDEADBEEF;
        @(posedge clk_i);
        #1;
        chk("in_rst_push_ignored", 32'(usage_o), 0);
        chk("in_rst_empty", 32'(empty_o), 1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        pop_i   = 1'b0;
        data_i  = 32'h00000011;
        @(posedge clk_i);
        #1;
        push_i = 1'b0;
        chk("post_rst_empty", 32'(empty_o), 0);
        chk("post_rst_usage", 32'(usage_o), 1);
        chk("post_rst_head", data_o, 32'h00000011);
`ifdef DRAM_FIFO_ERR_EN
        chk("post_rst_err", 32'(err_o), 0);
`endif
        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
